// File: rtl/pomodoro_display_pkg.sv
// rtl/pomodoro_display_pkg.sv - shared state codes, durations, segment table and helpers for pomodoro_display
package pomodoro_display_pkg;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_RUN5   = 4'd1;
  localparam logic [3:0] ST_RUN10  = 4'd2;
  localparam logic [3:0] ST_RUN25  = 4'd3;
  localparam logic [3:0] ST_PAUSED = 4'd4;
  localparam logic [3:0] ST_DONE   = 4'd5;

  localparam logic [15:0] DUR_5  = 16'd300;
  localparam logic [15:0] DUR_10 = 16'd600;
  localparam logic [15:0] DUR_25 = 16'd1500;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  // Serial scan phases: one half-period of sclk each
  localparam logic [2:0] SP_LOAD   = 3'd0;
  localparam logic [2:0] SP_LOW    = 3'd1;
  localparam logic [2:0] SP_HIGH   = 3'd2;
  localparam logic [2:0] SP_LATCH1 = 3'd3;
  localparam logic [2:0] SP_LATCH2 = 3'd4;

  typedef struct packed {
    logic [3:0]  st;
    logic [15:0] secs;
  } start_t;

  function automatic logic [7:0] seg_encode(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  function automatic logic is_run(input logic [3:0] s);
    return (s == ST_RUN5) || (s == ST_RUN10) || (s == ST_RUN25);
  endfunction

  function automatic logic [7:0] bcd2(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

endpackage

// File: rtl/pomodoro_display_if.sv
// rtl/pomodoro_display_if.sv - button inputs and 74HC595 serial link of pomodoro_display
interface pomodoro_display_if;
  logic [3:0] btn;
  logic       sclk;
  logic       rclk;
  logic       dio;

  modport master (output btn, input sclk, rclk, dio);
  modport slave  (input btn, output sclk, rclk, dio);
endinterface

// File: rtl/pomodoro_display_hc595_scan.sv
// rtl/pomodoro_display_hc595_scan.sv - shifts segment+select frames for digits 0..7 into a dual-74HC595 module
module hc595_scan
  import pomodoro_display_pkg::*;
#(
  parameter logic [15:0] SCLK_DIV = 16'd4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0][7:0] i_num,
  output logic            o_sclk,
  output logic            o_rclk,
  output logic            o_dio
);

  logic [15:0] r_div;
  logic [2:0]  r_phase;
  logic [3:0]  r_bit;
  logic [2:0]  r_digit;
  logic        r_sclk;
  logic        r_rclk;
  logic        r_dio;
  logic        w_step;
  logic [15:0] w_frame;

  assign w_step  = (r_div == SCLK_DIV - 16'd1);
  assign w_frame = {i_num[r_digit], 8'd1 << r_digit};

  // dio is only updated on transitions into a low sclk half, so it is stable at every rising edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div   <= '0;
      r_phase <= SP_LOAD;
      r_bit   <= 4'd15;
      r_digit <= '0;
      r_sclk  <= 1'b0;
      r_rclk  <= 1'b0;
      r_dio   <= 1'b0;
    end else begin
      r_div <= w_step ? 16'd0 : r_div + 16'd1;
      if (w_step) begin
        case (r_phase)
          SP_LOAD: begin
            r_dio   <= w_frame[r_bit];
            r_phase <= SP_LOW;
          end
          SP_LOW: begin
            r_sclk  <= 1'b1;
            r_phase <= SP_HIGH;
          end
          SP_HIGH: begin
            r_sclk <= 1'b0;
            if (r_bit == 4'd0) begin
              r_dio   <= 1'b0;
              r_rclk  <= 1'b1;
              r_phase <= SP_LATCH1;
            end else begin
              r_bit   <= r_bit - 4'd1;
              r_dio   <= w_frame[r_bit - 4'd1];
              r_phase <= SP_LOW;
            end
          end
          SP_LATCH1: r_phase <= SP_LATCH2;
          default: begin
            r_rclk  <= 1'b0;
            r_bit   <= 4'd15;
            r_digit <= r_digit + 3'd1;
            r_phase <= SP_LOAD;
          end
        endcase
      end
    end
  end

  assign o_sclk = r_sclk;
  assign o_rclk = r_rclk;
  assign o_dio  = r_dio;

endmodule

// File: rtl/pomodoro_display.sv
// rtl/pomodoro_display.sv - pomodoro timer with MM:SS display on a 74HC595 module; optional pause via POMODORO_PAUSE_EN
module pomodoro_display
  import pomodoro_display_pkg::*;
#(
  parameter logic [26:0] COUNT_LIM = 27'd100_000_000,
  parameter logic [15:0] SCLK_DIV  = 16'd4
) (
  input  logic               clk,
  input  logic               rst,
  pomodoro_display_if.slave  bus,
  output logic [15:0]        displayed_number,
  output logic [15:0]        mod_cnt,
  output logic [26:0]        one_second_counter,
  output logic [3:0]         state,
  output logic [3:0]         next_state,
  output logic [3:0]         LED_0,
  output logic [3:0]         LED_1,
  output logic [3:0]         LED_2,
  output logic [3:0]         LED_3,
  output logic [3:0]         LED_4,
  output logic [3:0]         LED_5,
  output logic [3:0]         LED_6,
  output logic [3:0]         LED_7,
  output logic [7:0]         NUM_0,
  output logic [7:0]         NUM_1,
  output logic [7:0]         NUM_2,
  output logic [7:0]         NUM_3,
  output logic [7:0]         NUM_4,
  output logic [7:0]         NUM_5,
  output logic [7:0]         NUM_6,
  output logic [7:0]         NUM_7
);

  logic [3:0]      r_btn_prev;
  logic [3:0]      r_state;
  logic [15:0]     r_mod_cnt;
  logic [26:0]     r_sec_cnt;
  logic [3:0]      w_rise;
  logic [3:0]      w_next;
  logic            w_run;
  logic            w_tick;
  logic            w_pause;
  logic            w_start_hit;
  start_t          w_start;
  logic [6:0]      w_min;
  logic [6:0]      w_sec;
  logic [15:0]     w_bcd;
  logic [7:0][7:0] w_num;
  logic            w_sclk;
  logic            w_rclk;
  logic            w_dio;

  assign w_rise      = bus.btn & ~r_btn_prev;
  assign w_run       = is_run(r_state);
  assign w_tick      = w_run && (r_sec_cnt == COUNT_LIM - 27'd1);
  assign w_start_hit = |w_rise[3:1];

  always_comb begin
    w_start = '{st: ST_RUN25, secs: DUR_25};
    if (w_rise[3])      w_start = '{st: ST_RUN5,  secs: DUR_5};
    else if (w_rise[2]) w_start = '{st: ST_RUN10, secs: DUR_10};
  end

`ifdef POMODORO_PAUSE_EN
  logic [3:0] r_saved;
  assign w_pause = w_rise[0] && (w_run || (r_state == ST_PAUSED));
`else
  logic w_unused_pause_btn;
  assign w_unused_pause_btn = w_rise[0];
  assign w_pause = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    if (w_start_hit) begin
      w_next = w_start.st;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: w_next = r_state;
        ST_RUN5, ST_RUN10, ST_RUN25: begin
          if (w_pause)                               w_next = ST_PAUSED;
          else if (w_tick && (r_mod_cnt <= 16'd1))   w_next = ST_DONE;
        end
`ifdef POMODORO_PAUSE_EN
        ST_PAUSED: if (w_pause) w_next = r_saved;
`endif
        default: w_next = ST_IDLE;
      endcase
    end
  end

  // A start press always reloads; pausing freezes both the prescaler and the remaining time
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_mod_cnt  <= '0;
      r_sec_cnt  <= '0;
      r_btn_prev <= '0;
    end else begin
      r_btn_prev <= bus.btn;
      r_state    <= w_next;
      if (w_start_hit) begin
        r_mod_cnt <= w_start.secs;
        r_sec_cnt <= '0;
      end else if (w_run && !w_pause) begin
        if (w_tick) begin
          r_sec_cnt <= '0;
          r_mod_cnt <= (r_mod_cnt <= 16'd1) ? 16'd0 : r_mod_cnt - 16'd1;
        end else begin
          r_sec_cnt <= r_sec_cnt + 27'd1;
        end
      end else if (w_next == ST_IDLE) begin
        r_mod_cnt <= '0;
        r_sec_cnt <= '0;
      end
    end
  end

`ifdef POMODORO_PAUSE_EN
  always_ff @(posedge clk) begin
    if (rst)                                    r_saved <= ST_RUN5;
    else if (w_run && w_pause && !w_start_hit)  r_saved <= r_state;
  end
`endif

  assign w_min = 7'(r_mod_cnt / 16'd60);
  assign w_sec = 7'(r_mod_cnt % 16'd60);
  assign w_bcd = {bcd2(w_min), bcd2(w_sec)};

  assign displayed_number   = w_bcd;
  assign mod_cnt            = r_mod_cnt;
  assign one_second_counter = r_sec_cnt;
  assign state              = r_state;
  assign next_state         = w_next;

  assign LED_0 = w_bcd[3:0];
  assign LED_1 = w_bcd[7:4];
  assign LED_2 = w_bcd[11:8];
  assign LED_3 = w_bcd[15:12];
  assign LED_4 = BLANK_CODE;
  assign LED_5 = BLANK_CODE;
  assign LED_6 = BLANK_CODE;
  assign LED_7 = BLANK_CODE;

  assign NUM_0 = seg_encode(LED_0);
  assign NUM_1 = seg_encode(LED_1);
  assign NUM_2 = seg_encode(LED_2);
  assign NUM_3 = seg_encode(LED_3);
  assign NUM_4 = seg_encode(LED_4);
  assign NUM_5 = seg_encode(LED_5);
  assign NUM_6 = seg_encode(LED_6);
  assign NUM_7 = seg_encode(LED_7);

  assign w_num = {NUM_7, NUM_6, NUM_5, NUM_4, NUM_3, NUM_2, NUM_1, NUM_0};

  hc595_scan #(
    .SCLK_DIV (SCLK_DIV)
  ) u_scan (
    .clk    (clk),
    .rst    (rst),
    .i_num  (w_num),
    .o_sclk (w_sclk),
    .o_rclk (w_rclk),
    .o_dio  (w_dio)
  );

  assign bus.sclk = w_sclk;
  assign bus.rclk = w_rclk;
  assign bus.dio  = w_dio;

endmodule

// File: tb/tb_pomodoro_display.sv
// tb/tb_pomodoro_display.sv - directed self-checking bench for pomodoro_display
module tb_pomodoro_display;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] displayed_number;
  logic [15:0] mod_cnt;
  logic [26:0] one_second_counter;
  logic [3:0]  state;
  logic [3:0]  next_state;
  logic [3:0]  LED_0, LED_1, LED_2, LED_3, LED_4, LED_5, LED_6, LED_7;
  logic [7:0]  NUM_0, NUM_1, NUM_2, NUM_3, NUM_4, NUM_5, NUM_6, NUM_7;

  int n_checks = 0;
  int n_errors = 0;

  pomodoro_display_if bus ();

  pomodoro_display #(
    .COUNT_LIM (27'd1),
    .SCLK_DIV  (16'd2)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .bus                (bus),
    .displayed_number   (displayed_number),
    .mod_cnt            (mod_cnt),
    .one_second_counter (one_second_counter),
    .state              (state),
    .next_state         (next_state),
    .LED_0 (LED_0), .LED_1 (LED_1), .LED_2 (LED_2), .LED_3 (LED_3),
    .LED_4 (LED_4), .LED_5 (LED_5), .LED_6 (LED_6), .LED_7 (LED_7),
    .NUM_0 (NUM_0), .NUM_1 (NUM_1), .NUM_2 (NUM_2), .NUM_3 (NUM_3),
    .NUM_4 (NUM_4), .NUM_5 (NUM_5), .NUM_6 (NUM_6), .NUM_7 (NUM_7)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic capture_frame(output logic [15:0] frame, output int rclk_w, output bit ok);
    logic prev_sclk;
    int   bits;
    int   budget;
    frame     = '0;
    bits      = 0;
    budget    = 0;
    rclk_w    = 0;
    prev_sclk = bus.sclk;
    while (bits < 16 && budget < 400) begin
      @(negedge clk);
      budget++;
      if (bus.sclk && !prev_sclk) begin
        frame = {frame[14:0], bus.dio};
        bits++;
      end
      prev_sclk = bus.sclk;
    end
    while (!bus.rclk && budget < 400) begin
      @(negedge clk);
      budget++;
    end
    while (bus.rclk && budget < 400) begin
      rclk_w++;
      @(negedge clk);
      budget++;
    end
    ok = (budget < 400);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.btn = 4'b0000;
    step(3);
    n_checks++; if (state !== 4'd0) begin n_errors++; $display("FAIL reset_state got=%0d exp=0", state); end
    n_checks++; if (next_state !== 4'd0) begin n_errors++; $display("FAIL reset_next_state got=%0d exp=0", next_state); end
    n_checks++; if (mod_cnt !== 16'd0) begin n_errors++; $display("FAIL reset_mod_cnt got=%0d exp=0", mod_cnt); end
    n_checks++; if (one_second_counter !== 27'd0) begin n_errors++; $display("FAIL reset_prescaler got=%0d exp=0", one_second_counter); end
    n_checks++; if (displayed_number !== 16'h0000) begin n_errors++; $display("FAIL reset_display got=%h exp=0000", displayed_number); end
    n_checks++; if ({bus.sclk, bus.rclk, bus.dio} !== 3'b000) begin n_errors++; $display("FAIL reset_serial got=%b exp=000", {bus.sclk, bus.rclk, bus.dio}); end
    n_checks++; if (LED_4 !== 4'hF) begin n_errors++; $display("FAIL reset_led4_blank got=%h exp=f", LED_4); end
    n_checks++; if (NUM_0 !== 8'hC0) begin n_errors++; $display("FAIL reset_num0 got=%h exp=c0", NUM_0); end
    n_checks++; if (NUM_5 !== 8'hFF) begin n_errors++; $display("FAIL reset_num5_blank got=%h exp=ff", NUM_5); end
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_run5();
    bus.btn = 4'b1000;
    step(1);
    n_checks++; if (state !== 4'd1) begin n_errors++; $display("FAIL run5_state got=%0d exp=1", state); end
    n_checks++; if (mod_cnt !== 16'd300) begin n_errors++; $display("FAIL run5_load got=%0d exp=300", mod_cnt); end
    n_checks++; if (displayed_number !== 16'h0500) begin n_errors++; $display("FAIL run5_display got=%h exp=0500", displayed_number); end
    n_checks++; if (NUM_2 !== 8'h92) begin n_errors++; $display("FAIL run5_num2 got=%h exp=92", NUM_2); end
    step(1);
    n_checks++; if (displayed_number !== 16'h0459) begin n_errors++; $display("FAIL run5_display_459 got=%h exp=0459", displayed_number); end
    n_checks++; if (NUM_0 !== 8'h90 || LED_1 !== 4'd5) begin n_errors++; $display("FAIL run5_digits got=%h/%h exp=90/5", NUM_0, LED_1); end
    step(3);
    bus.btn = 4'b0000;
    n_checks++; if (mod_cnt !== 16'd296) begin n_errors++; $display("FAIL run5_held_btn got=%0d exp=296", mod_cnt); end
    step(295);
    n_checks++; if (mod_cnt !== 16'd1 || state !== 4'd1) begin n_errors++; $display("FAIL run5_last_sec got=%0d/%0d exp=1/1", mod_cnt, state); end
    n_checks++; if (next_state !== 4'd5) begin n_errors++; $display("FAIL run5_next_done got=%0d exp=5", next_state); end
    step(1);
    n_checks++; if (state !== 4'd5 || mod_cnt !== 16'd0) begin n_errors++; $display("FAIL run5_done got=%0d/%0d exp=5/0", state, mod_cnt); end
    step(10);
    n_checks++; if (state !== 4'd5 || mod_cnt !== 16'd0 || displayed_number !== 16'h0000) begin n_errors++; $display("FAIL run5_done_hold got=%0d/%0d/%h exp=5/0/0000", state, mod_cnt, displayed_number); end
  endtask

  task automatic test_run10();
    bus.btn = 4'b1000;
    step(1);
    n_checks++; if (state !== 4'd1 || mod_cnt !== 16'd300) begin n_errors++; $display("FAIL restart_done got=%0d/%0d exp=1/300", state, mod_cnt); end
    bus.btn = 4'b0000;
    step(1);
    bus.btn = 4'b0100;
    step(1);
    bus.btn = 4'b0000;
    n_checks++; if (state !== 4'd2 || mod_cnt !== 16'd600) begin n_errors++; $display("FAIL run10_load got=%0d/%0d exp=2/600", state, mod_cnt); end
    n_checks++; if (displayed_number !== 16'h1000) begin n_errors++; $display("FAIL run10_display got=%h exp=1000", displayed_number); end
    step(599);
    n_checks++; if (state !== 4'd2 || mod_cnt !== 16'd1) begin n_errors++; $display("FAIL run10_last_sec got=%0d/%0d exp=2/1", state, mod_cnt); end
    step(1);
    n_checks++; if (state !== 4'd5 || mod_cnt !== 16'd0) begin n_errors++; $display("FAIL run10_done got=%0d/%0d exp=5/0", state, mod_cnt); end
  endtask

  task automatic test_override();
    bus.btn = 4'b0100;
    step(1);
    bus.btn = 4'b0000;
    step(300);
    n_checks++; if (state !== 4'd2 || mod_cnt !== 16'd300) begin n_errors++; $display("FAIL override_pre got=%0d/%0d exp=2/300", state, mod_cnt); end
    bus.btn = 4'b1000;
    step(1);
    bus.btn = 4'b0000;
    n_checks++; if (state !== 4'd1 || mod_cnt !== 16'd300) begin n_errors++; $display("FAIL override_reload got=%0d/%0d exp=1/300", state, mod_cnt); end
    step(1);
    n_checks++; if (mod_cnt !== 16'd299) begin n_errors++; $display("FAIL override_count got=%0d exp=299", mod_cnt); end
  endtask

  task automatic test_priority();
    bus.btn = 4'b1010;
    step(1);
    bus.btn = 4'b0000;
    n_checks++; if (state !== 4'd1 || mod_cnt !== 16'd300) begin n_errors++; $display("FAIL prio_3_over_1 got=%0d/%0d exp=1/300", state, mod_cnt); end
    step(1);
    bus.btn = 4'b0110;
    step(1);
    bus.btn = 4'b0000;
    n_checks++; if (state !== 4'd2 || mod_cnt !== 16'd600) begin n_errors++; $display("FAIL prio_2_over_1 got=%0d/%0d exp=2/600", state, mod_cnt); end
    step(1);
    bus.btn = 4'b0011;
    step(1);
    bus.btn = 4'b0000;
    n_checks++; if (state !== 4'd3 || mod_cnt !== 16'd1500) begin n_errors++; $display("FAIL prio_start_over_pause got=%0d/%0d exp=3/1500", state, mod_cnt); end
    n_checks++; if (displayed_number !== 16'h2500) begin n_errors++; $display("FAIL run25_display got=%h exp=2500", displayed_number); end
  endtask

  task automatic test_pause();
    step(1);
    bus.btn = 4'b0001;
    step(1);
`ifdef POMODORO_PAUSE_EN
    n_checks++; if (state !== 4'd4 || mod_cnt !== 16'd1499) begin n_errors++; $display("FAIL pause_enter got=%0d/%0d exp=4/1499", state, mod_cnt); end
    step(3);
    bus.btn = 4'b0000;
    step(2);
    n_checks++; if (state !== 4'd4 || mod_cnt !== 16'd1499) begin n_errors++; $display("FAIL pause_frozen got=%0d/%0d exp=4/1499", state, mod_cnt); end
    bus.btn = 4'b0001;
    step(1);
    bus.btn = 4'b0000;
    n_checks++; if (state !== 4'd3 || mod_cnt !== 16'd1499) begin n_errors++; $display("FAIL pause_resume got=%0d/%0d exp=3/1499", state, mod_cnt); end
    step(1);
    n_checks++; if (mod_cnt !== 16'd1498) begin n_errors++; $display("FAIL pause_recount got=%0d exp=1498", mod_cnt); end
`else
    n_checks++; if (state !== 4'd3 || mod_cnt !== 16'd1498) begin n_errors++; $display("FAIL pause_ignored got=%0d/%0d exp=3/1498", state, mod_cnt); end
    step(3);
    bus.btn = 4'b0000;
    n_checks++; if (state !== 4'd3 || mod_cnt !== 16'd1495) begin n_errors++; $display("FAIL pause_ignored_run got=%0d/%0d exp=3/1495", state, mod_cnt); end
`endif
  endtask

  task automatic test_reset_midrun();
    bus.btn = 4'b0100;
    step(1);
    bus.btn = 4'b0000;
    n_checks++; if (state !== 4'd2 || mod_cnt !== 16'd600) begin n_errors++; $display("FAIL midrun_load got=%0d/%0d exp=2/600", state, mod_cnt); end
    step(10);
    n_checks++; if (mod_cnt !== 16'd590) begin n_errors++; $display("FAIL midrun_count got=%0d exp=590", mod_cnt); end
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    n_checks++; if (state !== 4'd0 || mod_cnt !== 16'd0 || one_second_counter !== 27'd0) begin n_errors++; $display("FAIL midrun_abort got=%0d/%0d/%0d exp=0/0/0", state, mod_cnt, one_second_counter); end
    n_checks++; if (displayed_number !== 16'h0000) begin n_errors++; $display("FAIL midrun_display got=%h exp=0000", displayed_number); end
    step(1);
    n_checks++; if (state !== 4'd0 || mod_cnt !== 16'd0) begin n_errors++; $display("FAIL midrun_stays_idle got=%0d/%0d exp=0/0", state, mod_cnt); end
  endtask

  task automatic test_serial();
    logic [15:0] frame;
    logic [15:0] exp_frame;
    logic [7:0]  sel;
    int          rclk_w;
    bit          ok;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      sel       = 8'(1 << k);
      exp_frame = (k < 4) ? {8'hC0, sel} : {8'hFF, sel};
      capture_frame(frame, rclk_w, ok);
      n_checks++; if (!ok) begin n_errors++; $display("FAIL serial_timeout digit=%0d got=timeout exp=frame", k); end
      n_checks++; if (frame !== exp_frame) begin n_errors++; $display("FAIL serial_frame digit=%0d got=%h exp=%h", k, frame, exp_frame); end
      n_checks++; if (rclk_w != 4) begin n_errors++; $display("FAIL serial_rclk_width digit=%0d got=%0d exp=4", k, rclk_w); end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.btn = 4'b0000;
    test_reset();
    test_run5();
    test_run10();
    test_override();
    test_priority();
    test_pause();
    test_reset_midrun();
    test_serial();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
